// File: rtl/seg_pkg.sv
// Shared types, constants and hex-to-segment decode for the 7-segment scan controller.
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } seg_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] ANODE_OFF = 4'b0000;
    localparam logic [3:0] ANODE_D0  = 4'b0001;
    localparam logic [3:0] ANODE_D1  = 4'b0010;
    localparam logic [3:0] ANODE_D2  = 4'b0100;
    localparam logic [3:0] ANODE_D3  = 4'b1000;

    function automatic logic [3:0] anode_onehot(input logic [1:0] digit);
        logic [3:0] a;
        case (digit)
            2'd0:    a = ANODE_D0;
            2'd1:    a = ANODE_D1;
            2'd2:    a = ANODE_D2;
            default: a = ANODE_D3;
        endcase
        return a;
    endfunction

    // Active-low cathodes, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment cathode pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with blank gap, PWM and double-buffered update.
// Optional macro SEG_LZB_EN enables leading-zero blanking on digits 3..1.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned CNT_W        = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_value,
    input  logic [3:0]  upd_dp,
    input  logic [3:0]  bright,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES == 0) ? CNT_W'(0) : CNT_W'(BLANK_CYCLES - 1);

    seg_state_e       state_q, state_n;
    logic [1:0]       digit_q, digit_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [3:0]       pwm_q, pwm_n;
    logic             pwm_en;

    logic [15:0]      disp_q, disp_n;
    logic [3:0]       disp_dp_q, disp_dp_n;
    logic [15:0]      shadow_q, shadow_n;
    logic [3:0]       shadow_dp_q, shadow_dp_n;
    logic             shadow_full_q, shadow_full_n;
    logic             xfer;

    logic [3:0]       nib_n;
    logic [6:0]       seg_dec;
    logic             lzb;

    assign upd_ready = ~shadow_full_q;
    assign xfer      = upd_valid & ~shadow_full_q;

    always_comb begin
        state_n = state_q;
        digit_n = digit_q;
        cnt_n   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_BLANK: begin
                if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
                    state_n = ST_SHOW;
                    cnt_n   = '0;
                end
            end
            default: begin
                if (cnt_q == TICK_LAST) begin
                    digit_n = digit_q - 2'd1;
                    cnt_n   = '0;
                    state_n = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                end
            end
        endcase
    end

    assign pwm_n  = pwm_q + 4'd1;
    assign pwm_en = (pwm_n <= bright);

    // frame_done_q marks the boundary cycle; outputs for the next slot use the post-swap value
    always_comb begin
        disp_n        = disp_q;
        disp_dp_n     = disp_dp_q;
        shadow_n      = shadow_q;
        shadow_dp_n   = shadow_dp_q;
        shadow_full_n = shadow_full_q;
        if (frame_done) begin
            if (shadow_full_q) begin
                disp_n        = shadow_q;
                disp_dp_n     = shadow_dp_q;
                shadow_full_n = 1'b0;
            end else if (xfer) begin
                disp_n    = upd_value;
                disp_dp_n = upd_dp;
            end
        end else if (xfer) begin
            shadow_n      = upd_value;
            shadow_dp_n   = upd_dp;
            shadow_full_n = 1'b1;
        end
    end

    assign nib_n = disp_n[{digit_n, 2'b00} +: 4];

    seg_hex_decode u_hex_decode (
        .nibble (nib_n),
        .seg    (seg_dec)
    );

`ifdef SEG_LZB_EN
    always_comb begin
        case (digit_n)
            2'd3:    lzb = (disp_n[15:12] == 4'h0);
            2'd2:    lzb = (disp_n[15:8] == 8'h00);
            2'd1:    lzb = (disp_n[15:4] == 12'h000);
            default: lzb = 1'b0;
        endcase
    end
`else
    always_comb begin
        lzb = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BLANK;
            digit_q       <= 2'd3;
            cnt_q         <= '0;
            pwm_q         <= '0;
            disp_q        <= '0;
            disp_dp_q     <= '0;
            shadow_q      <= '0;
            shadow_dp_q   <= '0;
            shadow_full_q <= 1'b0;
            anode         <= ANODE_OFF;
            seg           <= SEG_BLANK;
            dp            <= 1'b1;
            frame_done    <= 1'b0;
        end else begin
            state_q       <= state_n;
            digit_q       <= digit_n;
            cnt_q         <= cnt_n;
            pwm_q         <= pwm_n;
            disp_q        <= disp_n;
            disp_dp_q     <= disp_dp_n;
            shadow_q      <= shadow_n;
            shadow_dp_q   <= shadow_dp_n;
            shadow_full_q <= shadow_full_n;
            frame_done    <= (state_n == ST_SHOW) && (digit_n == 2'd0) && (cnt_n == TICK_LAST);
            if (state_n == ST_SHOW) begin
                anode <= pwm_en ? anode_onehot(digit_n) : ANODE_OFF;
                seg   <= lzb ? SEG_BLANK : seg_dec;
                dp    <= ~disp_dp_n[digit_n];
            end else begin
                anode <= ANODE_OFF;
                seg   <= SEG_BLANK;
                dp    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a slot/frame arithmetic reference model.
module tb_seg_scan_ctrl;

    localparam int T     = 32;
    localparam int B     = 2;
    localparam int SLOT  = T + B;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [15:0] upd_value = '0;
    logic [3:0]  upd_dp = '0;
    logic [3:0]  bright = 4'd15;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    seg_scan_ctrl #(
        .TICK_DIV     (T),
        .BLANK_CYCLES (B),
        .CNT_W        (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_value  (upd_value),
        .upd_dp     (upd_dp),
        .bright     (bright),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] hex_tab [16];

    // Model: n = clock edges since reset release; display/shadow per handshake rules
    int          n;
    logic [15:0] m_disp;
    logic [3:0]  m_dp;
    logic        m_full;
    logic [15:0] m_sh;
    logic [3:0]  m_shdp;
    int          hi_cnt;
    int          last_fd;
    int          fd_gap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h (n=%0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d);
        logic [15:0] rest;
        rest = m_disp >> (4 * d);
`ifdef SEG_LZB_EN
        if (d > 0 && rest == 16'h0) return 7'h7F;
`endif
        return hex_tab[rest[3:0]];
    endfunction

    task automatic model_reset();
        n      = 0;
        m_disp = '0;
        m_dp   = '0;
        m_full = 1'b0;
        last_fd = -1;
    endtask

    // Called at a negedge with inputs already set; ends at the following negedge
    task automatic tick();
        int         c, idx, d, off;
        logic       xfer;
        logic [3:0] b;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        c    = n;
        b    = bright;
        xfer = upd_valid && !m_full;
        if ((c % FRAME) == FRAME - 1) begin
            if (m_full) begin
                m_disp = m_sh;
                m_dp   = m_shdp;
                m_full = 1'b0;
            end else if (xfer) begin
                m_disp = upd_value;
                m_dp   = upd_dp;
            end
        end else if (xfer) begin
            m_sh   = upd_value;
            m_shdp = upd_dp;
            m_full = 1'b1;
        end
        @(posedge clk);
        #1;
        n   = c + 1;
        idx = n % FRAME;
        d   = 3 - idx / SLOT;
        off = idx % SLOT;
        if (off < B) begin
            e_an  = 4'b0000;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            e_an  = ((n % 16) <= int'(b)) ? (4'b0001 << d) : 4'b0000;
            e_seg = exp_seg(d);
            e_dp  = ~m_dp[d];
        end
        check("outputs", {18'd0, anode, seg, dp, frame_done, upd_ready},
              {18'd0, e_an, e_seg, e_dp, (idx == FRAME - 1), ~m_full});
        if (d == 3 && anode != 4'b0000) hi_cnt++;
        if (frame_done) begin
            if (last_fd >= 0) fd_gap = n - last_fd;
            last_fd = n;
        end
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    initial begin
        int f;
        int br_val [3];
        int br_exp [3];
        hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        br_val = '{0, 7, 15};
        br_exp = '{2, 16, 32};
        hi_cnt = 0;
        fd_gap = 0;
        model_reset();

        // Reset state and release latency
        repeat (3) @(negedge clk);
        check("reset_state", {anode, seg, dp, frame_done, upd_ready}, {4'b0000, 7'h7F, 1'b1, 1'b0, 1'b1});
        reset = 1'b0;
        model_reset();
        check("rel_edge0", anode, 4'b0000);
        tick();
        check("rel_edge1", anode, 4'b0000);
        tick();
        check("rel_edge2", anode, 4'b1000);

        // Single update, visible from the next frame
        upd_valid = 1'b1;
        upd_value = 16'h1234;
        upd_dp    = 4'b0001;
        tick();
        upd_valid = 1'b0;
        run_to(FRAME + 10);
        check("d3_1234", {seg, dp}, {7'b1111001, 1'b1});
        run_to(FRAME + SLOT + 10);
        check("d2_1234", {seg, dp}, {7'b0100100, 1'b1});
        run_to(FRAME + 2 * SLOT + 10);
        check("d1_1234", {seg, dp}, {7'b0110000, 1'b1});
        run_to(FRAME + 3 * SLOT + 10);
        check("d0_1234", {seg, dp}, {7'b0011001, 1'b0});

        // Back-to-back offers: second one waits for the boundary
        upd_valid = 1'b1;
        upd_value = 16'hAAAA;
        upd_dp    = 4'b0000;
        tick();
        upd_value = 16'h5555;
        check("ready_low", upd_ready, 1'b0);
        f = 0;
        while (m_full && f < 2 * FRAME) begin
            tick();
            f++;
        end
        check("shadow_drain", m_full, 1'b0);
        tick();
        upd_valid = 1'b0;
        run_to(2 * FRAME + 10);
        check("frame_AAAA", seg, 7'b0001000);
        run_to(3 * FRAME + 10);
        check("frame_5555", seg, 7'b0010010);

        // Brightness duty per SHOW slot and frame period
        for (int i = 0; i < 3; i++) begin
            bright = br_val[i][3:0];
            run_to((n / FRAME + 1) * FRAME);
            hi_cnt = 0;
            run_to(n + SLOT);
            check("bright_duty", hi_cnt, br_exp[i]);
        end
        run_to(n + 2 * FRAME);
        check("fd_period", fd_gap, FRAME);

        // Randomized traffic against the model
        for (int i = 0; i < 6 * FRAME; i++) begin
            upd_valid = ($urandom_range(0, 7) == 0);
            upd_value = 16'($urandom);
            upd_dp    = 4'($urandom);
            if ($urandom_range(0, 63) == 0) bright = 4'($urandom);
            tick();
        end
        upd_valid = 1'b0;
        bright    = 4'd15;

        // Reset during digit 1 SHOW with a pending shadow value
        f = 0;
        while ((n % FRAME) != 2 * SLOT + B + 10 && f < 2 * FRAME) begin
            tick();
            f++;
        end
        if (!m_full) begin
            upd_valid = 1'b1;
            upd_value = 16'hC0DE;
            upd_dp    = 4'b1111;
            tick();
            upd_valid = 1'b0;
        end
        check("pending_before_rst", upd_ready, 1'b0);
        check("digit1_before_rst", anode & 4'b1101, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", {anode, seg, dp, frame_done, upd_ready}, {4'b0000, 7'h7F, 1'b1, 1'b0, 1'b1});
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_to(10);
`ifdef SEG_LZB_EN
        check("post_rst_d3", seg, 7'h7F);
`else
        check("post_rst_d3", seg, 7'b1000000);
`endif
        run_to(FRAME + SLOT);

        // Leading-zero pattern 0x0050
        upd_valid = 1'b1;
        upd_value = 16'h0050;
        upd_dp    = 4'b0000;
        tick();
        upd_valid = 1'b0;
        run_to(2 * FRAME);
        hi_cnt = 0;
        run_to(2 * FRAME + SLOT);
        check("lzb_anode_d3", hi_cnt, 32);
        run_to(2 * FRAME + SLOT + 10);
`ifdef SEG_LZB_EN
        check("lzb_d2", seg, 7'h7F);
`else
        check("lzb_d2", seg, 7'b1000000);
`endif
        run_to(2 * FRAME + 2 * SLOT + 10);
        check("lzb_d1", seg, 7'b0010010);
        run_to(2 * FRAME + 3 * SLOT + 10);
        check("lzb_d0", seg, 7'b1000000);
        run_to(3 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
